// File: rtl/scoreboard_regfile.sv
// scoreboard_regfile: parametrised register file with a per-register busy
// scoreboard for multi-cycle producers, an optional same-cycle write-to-read
// bypass and an optional hardwired-zero register 0.
module scoreboard_regfile #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rsNum,
  input  logic [ADDR_W-1:0] rtNum,
  output logic [WIDTH-1:0]  rsData,
  output logic [WIDTH-1:0]  rtData,
  output logic              rsBusy,
  output logic              rtBusy,
  input  logic [ADDR_W-1:0] rdNum,
  input  logic [WIDTH-1:0]  rdData,
  input  logic              rdWriteEnable,
  input  logic [ADDR_W-1:0] reserveNum,
  input  logic              reserveEnable,
  output logic [ADDR_W:0]   busyCount,
  output logic              wawError
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;

  logic rdIsZero;
  logic reserveIsZero;
  logic writeEn;
  logic reserveEn;
  logic countInc;
  logic countDec;
  logic wawHit;

  // Register 0 is neither written nor reserved when it is hardwired to zero.
  assign rdIsZero      = (ZERO_REG != 0) && (rdNum == '0);
  assign reserveIsZero = (ZERO_REG != 0) && (reserveNum == '0);
  assign writeEn       = rdWriteEnable && !reset && !rdIsZero;
  assign reserveEn     = reserveEnable && !reset && !reserveIsZero;

  // A write to the register being reserved in the same cycle leaves it busy
  // (new producer), so it must not decrement the count.
  assign countInc = reserveEn && !busy[reserveNum];
  assign countDec = writeEn && busy[rdNum] && !(reserveEn && (reserveNum == rdNum));
  assign wawHit   = reserveEn && busy[reserveNum];

  // Read data: zero register, then same-cycle write bypass, then stored value.
  function automatic logic [WIDTH-1:0] readData(input logic [ADDR_W-1:0] num);
    if ((ZERO_REG != 0) && (num == '0)) return '0;
    if ((BYPASS != 0) && writeEn && (rdNum == num)) return rdData;
    return regs[num];
  endfunction

  // Read busy: a bypassed write clears busy unless a reserve re-marks it.
  function automatic logic readBusy(input logic [ADDR_W-1:0] num);
    if ((ZERO_REG != 0) && (num == '0)) return 1'b0;
    if ((BYPASS != 0) && writeEn && (rdNum == num)) return reserveEn && (reserveNum == num);
    return busy[num];
  endfunction

  // Port A combinational read.
  always_comb begin
    rsData = readData(rsNum);
    rsBusy = readBusy(rsNum);
  end

  // Port B combinational read.
  always_comb begin
    rtData = readData(rtNum);
    rtBusy = readBusy(rtNum);
  end

  // Storage, scoreboard, busy count and sticky WAW flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[ADDR_W'(i)] <= '0;
      end
      busy      <= '0;
      busyCount <= '0;
      wawError  <= 1'b0;
    end else begin
      if (writeEn) begin
        regs[rdNum] <= rdData;
        busy[rdNum] <= 1'b0;
      end
      // Issued after the write clear so a same-register reserve wins.
      if (reserveEn) begin
        busy[reserveNum] <= 1'b1;
      end
      busyCount <= busyCount + CNT_W'(countInc) - CNT_W'(countDec);
      wawError  <= wawError | wawHit;
    end
  end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// tb_scoreboard_regfile: drives two instances (default 32x32 with bypass, and
// 8x16 without bypass) from shared stimulus and compares both against an
// array-based reference model of the register file and its scoreboard.
module tb_scoreboard_regfile;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Shared stimulus; instance B uses the low address/data bits.
  logic        sRst   = 1'b1;
  logic [4:0]  sRs    = '0;
  logic [4:0]  sRt    = '0;
  logic [4:0]  sRd    = '0;
  logic [31:0] sRdData = '0;
  logic        sWe    = 1'b0;
  logic [4:0]  sRes   = '0;
  logic        sRe    = 1'b0;

  logic [31:0] aRsData, aRtData;
  logic        aRsBusy, aRtBusy, aWaw;
  logic [5:0]  aCount;
  logic [15:0] bRsData, bRtData;
  logic        bRsBusy, bRtBusy, bWaw;
  logic [3:0]  bCount;

  scoreboard_regfile #(.WIDTH(32), .ADDR_W(5), .BYPASS(1), .ZERO_REG(1)) dutA (
    .clock(clock), .reset(sRst),
    .rsNum(sRs), .rtNum(sRt),
    .rsData(aRsData), .rtData(aRtData), .rsBusy(aRsBusy), .rtBusy(aRtBusy),
    .rdNum(sRd), .rdData(sRdData), .rdWriteEnable(sWe),
    .reserveNum(sRes), .reserveEnable(sRe),
    .busyCount(aCount), .wawError(aWaw)
  );

  scoreboard_regfile #(.WIDTH(16), .ADDR_W(3), .BYPASS(0), .ZERO_REG(1)) dutB (
    .clock(clock), .reset(sRst),
    .rsNum(sRs[2:0]), .rtNum(sRt[2:0]),
    .rsData(bRsData), .rtData(bRtData), .rsBusy(bRsBusy), .rtBusy(bRtBusy),
    .rdNum(sRd[2:0]), .rdData(sRdData[15:0]), .rdWriteEnable(sWe),
    .reserveNum(sRes[2:0]), .reserveEnable(sRe),
    .busyCount(bCount), .wawError(bWaw)
  );

  // Reference model: index 0 = instance A, 1 = instance B.
  logic [31:0] mData [2][32];
  bit          mBusy [2][32];
  bit          mWaw  [2];

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int amask(input int k);
    return (k == 0) ? 31 : 7;
  endfunction

  function automatic logic [31:0] dmask(input int k);
    return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic bit bypassOn(input int k);
    return k == 0;
  endfunction

  function automatic bit weEff(input int k);
    return sWe && !sRst && ((int'(sRd) & amask(k)) != 0);
  endfunction

  function automatic bit reEff(input int k);
    return sRe && !sRst && ((int'(sRes) & amask(k)) != 0);
  endfunction

  function automatic logic [31:0] expData(input int k, input int num);
    int n = num & amask(k);
    if (n == 0) return 32'h0;
    if (bypassOn(k) && weEff(k) && ((int'(sRd) & amask(k)) == n)) return sRdData & dmask(k);
    return mData[k][n];
  endfunction

  function automatic logic [31:0] expBusy(input int k, input int num);
    int n = num & amask(k);
    if (n == 0) return 32'h0;
    if (bypassOn(k) && weEff(k) && ((int'(sRd) & amask(k)) == n))
      return {31'h0, reEff(k) && ((int'(sRes) & amask(k)) == n)};
    return {31'h0, mBusy[k][n]};
  endfunction

  // Busy count as a population count of the model's busy bits.
  function automatic logic [31:0] expCount(input int k);
    int c = 0;
    for (int i = 0; i <= amask(k); i++) c += int'(mBusy[k][i]);
    return 32'(c);
  endfunction

  // Apply one clock edge's worth of state change to the model.
  task automatic modelEdge(input int k);
    int rd  = int'(sRd) & amask(k);
    int res = int'(sRes) & amask(k);
    if (sRst) begin
      for (int i = 0; i < 32; i++) begin
        mData[k][i] = 32'h0;
        mBusy[k][i] = 1'b0;
      end
      mWaw[k] = 1'b0;
    end else begin
      if (reEff(k) && mBusy[k][res]) mWaw[k] = 1'b1;
      if (weEff(k)) begin
        mData[k][rd] = sRdData & dmask(k);
        mBusy[k][rd] = 1'b0;
      end
      if (reEff(k)) mBusy[k][res] = 1'b1;
    end
  endtask

  // Drive one cycle of stimulus, check both instances mid-cycle, then clock.
  task automatic step(input int rs, input int rt, input int rd, input logic [31:0] d,
                      input bit we, input int res, input bit re, input bit rst);
    logic [31:0] oRsD, oRtD, oRsB, oRtB, oCnt, oWaw;
    @(negedge clock);
    sRs = 5'(rs); sRt = 5'(rt); sRd = 5'(rd); sRdData = d;
    sWe = we; sRes = 5'(res); sRe = re; sRst = rst;
    #1;
    for (int k = 0; k < 2; k++) begin
      oRsD = (k == 0) ? aRsData : 32'(bRsData);
      oRtD = (k == 0) ? aRtData : 32'(bRtData);
      oRsB = (k == 0) ? 32'(aRsBusy) : 32'(bRsBusy);
      oRtB = (k == 0) ? 32'(aRtBusy) : 32'(bRtBusy);
      oCnt = (k == 0) ? 32'(aCount) : 32'(bCount);
      oWaw = (k == 0) ? 32'(aWaw) : 32'(bWaw);
      checkVal($sformatf("dut%0d rsData[%0d]", k, rs & amask(k)), oRsD, expData(k, rs));
      checkVal($sformatf("dut%0d rtData[%0d]", k, rt & amask(k)), oRtD, expData(k, rt));
      checkVal($sformatf("dut%0d rsBusy[%0d]", k, rs & amask(k)), oRsB, expBusy(k, rs));
      checkVal($sformatf("dut%0d rtBusy[%0d]", k, rt & amask(k)), oRtB, expBusy(k, rt));
      checkVal($sformatf("dut%0d busyCount", k), oCnt, expCount(k));
      checkVal($sformatf("dut%0d wawError", k), oWaw, 32'(mWaw[k]));
    end
    @(posedge clock);
    modelEdge(0);
    modelEdge(1);
  endtask

  function automatic int pickAddr();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
  endfunction

  initial begin
    // Initial reset: state is unknown beforehand, so nothing is compared.
    @(negedge clock);
    sRst = 1'b1;
    @(posedge clock);
    modelEdge(0);
    modelEdge(1);

    // Every register reads zero and idle after reset.
    for (int i = 0; i < 32; i++) step(i, 31 - i, 0, 0, 0, 0, 0, 0);

    // Same-cycle bypass of r5, then a write to r0 that must be dropped.
    step(5, 5, 5, 32'hDEAD_BEEF, 1, 0, 0, 0);
    step(5, 0, 0, 32'h0000_1234, 1, 0, 0, 0);
    step(0, 5, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);

    // Reserve r3, wait, then write r3=7.
    step(3, 3, 0, 0, 0, 3, 1, 0);
    for (int i = 0; i < 3; i++) step(3, 0, 0, 0, 0, 0, 0, 0);
    step(3, 3, 3, 32'h7, 1, 0, 0, 0);
    step(3, 3, 0, 0, 0, 0, 0, 0);

    // r9 busy, then written and reserved together: WAW and busy held.
    step(9, 9, 0, 0, 0, 9, 1, 0);
    step(9, 9, 9, 32'hAAAA_5555, 1, 9, 1, 0);
    step(9, 9, 0, 0, 0, 0, 0, 0);
    step(9, 1, 0, 0, 0, 0, 0, 0);

    // Reserve r2 while a busy r4 is written.
    step(4, 2, 0, 0, 0, 4, 1, 0);
    step(2, 4, 4, 32'h55, 1, 2, 1, 0);
    step(2, 4, 0, 0, 0, 0, 0, 0);

    // Reset mid-operation with a write to r1 in the reset cycle.
    step(1, 2, 0, 0, 0, 1, 1, 0);
    step(1, 2, 0, 0, 0, 2, 1, 0);
    step(1, 3, 0, 0, 0, 3, 1, 0);
    step(1, 2, 1, 32'h77, 1, 0, 0, 1);
    step(1, 3, 0, 0, 0, 0, 0, 0);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 800; n++) begin
      step(pickAddr(), pickAddr(), pickAddr(), $urandom, 1'($urandom_range(0, 1)),
           pickAddr(), $urandom_range(0, 2) == 0, $urandom_range(0, 99) < 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
